// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types and constants for the gate response checker
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_PATTERN = 32'h0000_0016;
    localparam int          VEC_IDX_W       = 5;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - per-vector settle counter, ticks on the sample cycle
module hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] hold_cnt;

    // Count cycles within one vector hold; clear restarts the next vector at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (clr) begin
            hold_cnt <= '0;
        end else if (en) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign tick = (hold_cnt == LAST_CNT);

endmodule

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - stimulus/response engine for a 1-bit gate under test
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int          NUM_VEC     = 5,
    parameter logic [31:0] PATTERN     = DEFAULT_PATTERN,
    parameter int          HOLD_CYCLES = 10,
    parameter int          INVERT      = 1,
    parameter int          CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dut_y,
    output logic                 stim_a,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [VEC_IDX_W-1:0] fail_index
);

    localparam logic                 INV_BIT  = (INVERT != 0);
    localparam logic [VEC_IDX_W-1:0] LAST_IDX = VEC_IDX_W'(NUM_VEC - 1);

    state_t               state, state_nxt;
    logic [VEC_IDX_W-1:0] vec_idx;
    logic [VEC_IDX_W-1:0] next_idx;
    logic                 tick;
    logic                 sample;
    logic                 expected;
    logic                 miss;
    logic                 last_vec;

    // The timer only runs in DRIVE and restarts at every vector boundary.
    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .clr ((state != DRIVE) || tick),
        .en  (1'b1),
        .tick(tick)
    );

    assign next_idx = vec_idx + 1'b1;
    assign sample   = (state == DRIVE) && tick;
    assign expected = PATTERN[vec_idx] ^ INV_BIT;
    assign miss     = sample && (dut_y != expected);
    assign last_vec = (vec_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start is only honoured from IDLE, so pulses while busy or in DONE drop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   if (sample && last_vec) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stimulus, vector index and run results; pass is settled including the final sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_a     <= 1'b0;
            vec_idx    <= '0;
            err_count  <= '0;
            fail_index <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stim_a     <= PATTERN[0];
                        vec_idx    <= '0;
                        err_count  <= '0;
                        fail_index <= '0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        if (miss) begin
                            if (err_count != '1) err_count <= err_count + 1'b1;
                            if (err_count == '0) fail_index <= vec_idx;
                        end
                        if (last_vec) begin
                            stim_a <= 1'b0;
                            pass   <= (err_count == '0) && !miss;
                        end else begin
                            vec_idx <= next_idx;
                            stim_a  <= PATTERN[next_idx];
                        end
                    end
                end
                default: begin
                    stim_a <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy     = (state == DRIVE);
        done     = (state == DONE);
        mismatch = miss;
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - directed self-checking bench for gate_response_checker
module tb_gate_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_b = 1'b0;
    int         mode = 0;   // 0 inverter, 1 stuck-0, 2 stuck-1, 3 buffer
    logic       dut_y;
    logic       stim_a, busy, done, mismatch, pass;
    logic [7:0] err_count;
    logic [4:0] fail_index;
    logic       stim_a_b, busy_b, done_b, mismatch_b, pass_b;
    logic [7:0] err_count_b;
    logic [4:0] fail_index_b;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [31:0] PAT = 32'h0000_0016;

    always #5 clk = ~clk;

    assign dut_y = (mode == 0) ? ~stim_a :
                   (mode == 1) ? 1'b0 :
                   (mode == 2) ? 1'b1 : stim_a;

    gate_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .dut_y(dut_y),
        .stim_a(stim_a), .busy(busy), .done(done), .mismatch(mismatch),
        .pass(pass), .err_count(err_count), .fail_index(fail_index)
    );

    gate_response_checker #(.INVERT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_y(stim_a_b),
        .stim_a(stim_a_b), .busy(busy_b), .done(done_b), .mismatch(mismatch_b),
        .pass(pass_b), .err_count(err_count_b), .fail_index(fail_index_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Start at the current negedge, watch the whole run, check results; returns one cycle after done.
    task automatic run_vectors(input string name, input int m, input bit poke,
                               input logic [4:0] exp_mask, input int exp_err,
                               input int exp_fidx, input bit exp_pass);
        int         cyc;
        int         stim_bad;
        logic [4:0] mask;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 0;
        stim_bad = 0;
        mask     = '0;
        while (busy && cyc < 50) begin
            if (stim_a !== PAT[cyc / 10]) stim_bad++;
            if (mismatch) begin
                mask[cyc / 10] = 1'b1;
                if (cyc % 10 != 9) stim_bad++;
            end
            start = poke && (cyc == 20 || cyc == 35);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, " busy_cycles"}, cyc, 50);
        check({name, " still_busy"}, busy, 0);
        check({name, " stim_timing"}, stim_bad, 0);
        check({name, " mismatch_vectors"}, mask, exp_mask);
        check({name, " done"}, done, 1);
        check({name, " stim_idle"}, stim_a, 0);
        check({name, " err_count"}, err_count, exp_err);
        check({name, " pass"}, pass, exp_pass);
        if (!exp_pass) check({name, " fail_index"}, fail_index, exp_fidx);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        check({name, " done_one_cycle"}, done, 0);
        check({name, " idle_after_done"}, busy, 0);
    endtask

    initial begin
        int cyc;
        #1;
        check("reset_async_outputs", {stim_a, busy, done, mismatch, pass, err_count, fail_index}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_vectors("inverter",  0, 1'b0, 5'h00, 0, 0, 1'b1);
        run_vectors("stuck0",    1, 1'b0, 5'h09, 2, 0, 1'b0);
        run_vectors("stuck1",    2, 1'b0, 5'h16, 3, 1, 1'b0);
        run_vectors("buffer",    3, 1'b0, 5'h1f, 5, 0, 1'b0);
        run_vectors("poke_run",  1, 1'b1, 5'h09, 2, 0, 1'b0);
        run_vectors("clean_run", 0, 1'b0, 5'h00, 0, 0, 1'b1);

        // Buffer against a non-inverting checker must pass.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("noninv_done_seen", done_b, 1);
        check("noninv_pass", pass_b, 1);
        check("noninv_err_count", err_count_b, 0);

        // Asynchronous reset in the middle of vector 2 of a failing run.
        @(negedge clk);
        mode  = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        check("midrun_busy", busy, 1);
        check("midrun_err_count", err_count, 2);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {stim_a, busy, done, mismatch, pass, err_count, fail_index}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vectors("after_reset", 0, 1'b0, 5'h00, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
